byte_bus_mem: RTL and testbench
===============================

BYTE_BUS_MEM -- requirements
Module: byte_bus_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of the number of 32-bit words held (16 words).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port frame_start, input, 1 bit; marks byte 0 of a host transaction.
REQ-006 SHALL have port rw, input, 1 bit; sampled with frame_start; 1 = read, 0 = write.
REQ-007 SHALL have port addr_in, input, 8 bits; host address byte lane, least significant byte first.
REQ-008 SHALL have port wdata_in, input, 8 bits; host write-data byte lane, least significant byte first.
REQ-009 SHALL have port rdata_out, output, 8 bits; read-data byte lane, least significant byte first.
REQ-010 SHALL have port rdata_oe, output, 1 bit; high while rdata_out carries a valid read byte.
REQ-011 SHALL have port busy, output, 1 bit; high while a transaction is in progress after C0.
REQ-012 SHALL have port done, output, 1 bit; one-cycle pulse at transaction end.
REQ-013 SHALL have port err, output, 1 bit; pulses together with done on a rejected access.

Function
REQ-014 SHALL implement FSM states IDLE, CAPT, RDAT; the C0 cycle is the IDLE cycle in which frame_start=1.
REQ-015 SHALL capture addr_in and wdata_in bytes in cycles C0..C3: C0 = bits 7:0, C1 = 15:8, C2 = 23:16, C3 = 31:24.
REQ-016 SHALL sample rw only in C0 and SHALL ignore rw during C1..C3.
REQ-017 SHALL ignore frame_start in every state except IDLE.
REQ-018 SHALL form the 32-bit address from bytes C0..C2 (registered) plus the addr_in byte present in C3.
REQ-019 SHALL mark the address valid when addr[1:0]==0 and BASE <= addr < BASE + 4*2^DEPTH_LOG2.
REQ-020 SHALL use word index (addr - BASE) >> 2.
REQ-021 Write, valid address: SHALL update the word on the C3 edge; done=1 in C4; busy=0 in C4.
REQ-022 Write, invalid address: SHALL leave memory unchanged; done=1 and err=1 in C4.
REQ-023 Read: SHALL drive rdata_out with word bytes 7:0, 15:8, 23:16, 31:24 in C4, C5, C6, C7; rdata_oe=1 in C4..C7 only.
REQ-024 Read, invalid address: SHALL return 8'h00 in C4..C7; err=1 with done.
REQ-025 Read: SHALL pulse done in C8.
REQ-026 Read: SHALL keep busy=1 in C1..C7.
REQ-027 Write: SHALL keep busy=1 in C1..C3.
REQ-028 SHALL drive rdata_out=8'h00 whenever rdata_oe=0.
REQ-029 A read of a word written by the immediately preceding transaction SHALL return the new value.
REQ-030 frame_start in the done cycle SHALL be accepted as C0 of a new transaction (back-to-back, no bubble).
REQ-031 All outputs SHALL be registered.
REQ-032 Index arithmetic SHALL be 32-bit unsigned; BASE + span SHALL NOT wrap (integration constraint).

Reset
REQ-033 rst=1 at a rising edge SHALL force state IDLE.
REQ-034 rst=1 SHALL clear all memory words to 32'h0.
REQ-035 rst=1 SHALL force rdata_out=8'h00, rdata_oe=0, busy=0, done=0, err=0.
REQ-036 rst mid-transaction SHALL abort it: no write, no done, no err.
REQ-037 rst=1 SHALL take priority over frame_start in the same cycle.

Verification
REQ-038 Write 32'hDEADBEEF to addr 32'h0000_0008, then read 32'h0000_0008 -> rdata_out EF, BE, AD, DE in C4..C7; done in C8; err=0.
REQ-039 Read 32'h0000_0040 (one past end at default parameters) -> four 8'h00 bytes; done=1 and err=1 in C8.
REQ-040 Write 32'h12345678 to misaligned addr 32'h0000_0006 -> err=1 in C4; read of 32'h0000_0004 returns 32'h0.
REQ-041 Back-to-back: write 32'hA5A5A5A5 @ 32'h0000_003C with frame_start again in its C4 as a read of 32'h0000_003C -> A5 x4 in the read's C4..C7.
REQ-042 rst asserted in C2 of a write of 32'h11111111 @ 32'h0000_0000 -> busy=0 next cycle; no done; later read returns 32'h0.
REQ-043 frame_start pulsed during C5 of a read -> ignored; read completes normally with exactly one done pulse.

Source files
------------

// File: rtl/byte_bus_mem.sv
// byte_bus_mem: small word memory behind a byte-serial host bus.
// A transaction carries a 32-bit address and 32-bit write data over four
// byte cycles (C0..C3, LSB first). Writes commit on the C3 edge; reads stream
// the selected word back LSB first in C4..C7 and finish with done in C8.
// Out-of-range or misaligned accesses are rejected with err alongside done.

module byte_bus_mem #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE       = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       rw,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata_in,
    output logic [7:0] rdata_out,
    output logic       rdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int          WORDS = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'(WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        RDAT = 2'd2
    } state_t;

    state_t      state;
    // In CAPT: number of the current byte cycle (1..3). In RDAT: index of
    // the byte currently on rdata_out (0..3).
    logic [1:0]  byte_cnt;
    logic        rw_q;
    logic [23:0] addr_q;
    logic [23:0] wdata_q;
    // Remaining read bytes (word bits 31:8), shifted down one byte per cycle.
    logic [23:0] rd_shift;
    logic        rd_err_q;

    logic [31:0] mem [WORDS];

    logic [31:0]           full_addr;
    logic [31:0]           full_wdata;
    logic [31:0]           offset;
    logic [31:0]           word_sel;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           rd_word;
    logic                  addr_ok;
    logic                  last_capt;
    logic                  mem_we;
    logic                  unused_word_sel;

    // Assemble the full address/data from the registered bytes plus the
    // byte lanes present in C3, and decode validity and word index.
    // NOTE: every signal gets a value on every path through always_comb;
    // a missing assignment would infer a latch.
    always_comb begin
        full_addr  = {addr_in, addr_q};
        full_wdata = {wdata_in, wdata_q};
        offset     = full_addr - BASE;
        addr_ok    = (full_addr[1:0] == 2'b00) && (full_addr >= BASE) &&
                     (offset < SPAN);
        word_sel   = offset >> 2;
        word_idx   = word_sel[DEPTH_LOG2-1:0];
        rd_word    = addr_ok ? mem[word_idx] : 32'h0;
        last_capt  = (state == CAPT) && (byte_cnt == 2'd3);
        mem_we     = last_capt && !rw_q && addr_ok;
    end

    // Upper index bits are always zero for a valid address; they only feed
    // the range check through offset.
    assign unused_word_sel = ^word_sel[31:DEPTH_LOG2];

    // Word storage: cleared by reset, written on the C3 edge of a valid write.
    // NOTE: the array is reset word by word because reset must leave every
    // word reading 0; this forces flip-flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_we) begin
            mem[word_idx] <= full_wdata;
        end
    end

    // Transaction FSM with registered outputs: byte capture, read streaming,
    // and done/err pulse generation.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            rw_q      <= 1'b0;
            addr_q    <= 24'h0;
            wdata_q   <= 24'h0;
            rd_shift  <= 24'h0;
            rd_err_q  <= 1'b0;
            rdata_out <= 8'h00;
            rdata_oe  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        rw_q          <= rw;
                        addr_q[7:0]   <= addr_in;
                        wdata_q[7:0]  <= wdata_in;
                        byte_cnt      <= 2'd1;
                        busy          <= 1'b1;
                        state         <= CAPT;
                    end
                end
                CAPT: begin
                    case (byte_cnt)
                        2'd1: begin
                            addr_q[15:8]  <= addr_in;
                            wdata_q[15:8] <= wdata_in;
                            byte_cnt      <= 2'd2;
                        end
                        2'd2: begin
                            addr_q[23:16]  <= addr_in;
                            wdata_q[23:16] <= wdata_in;
                            byte_cnt       <= 2'd3;
                        end
                        default: begin
                            if (rw_q) begin
                                rdata_out <= rd_word[7:0];
                                rd_shift  <= rd_word[31:8];
                                rdata_oe  <= 1'b1;
                                rd_err_q  <= !addr_ok;
                                byte_cnt  <= 2'd0;
                                state     <= RDAT;
                            end else begin
                                done  <= 1'b1;
                                err   <= !addr_ok;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    endcase
                end
                RDAT: begin
                    if (byte_cnt == 2'd3) begin
                        rdata_out <= 8'h00;
                        rdata_oe  <= 1'b0;
                        done      <= 1'b1;
                        err       <= rd_err_q;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rdata_out <= rd_shift[7:0];
                        rd_shift  <= {8'h00, rd_shift[23:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_bus_mem.sv
// Directed testbench for byte_bus_mem. Each cycle the bench advances to
// #1 after the rising edge, drives that cycle's inputs and checks outputs.

module tb_byte_bus_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       rw;
    logic [7:0] addr_in;
    logic [7:0] wdata_in;
    logic [7:0] rdata_out;
    logic       rdata_oe;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    byte_bus_mem dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .rw          (rw),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .rdata_out   (rdata_out),
        .rdata_oe    (rdata_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        frame_start = 1'b0;
        rw          = 1'b0;
        addr_in     = 8'h00;
        wdata_in    = 8'h00;
        next_cycle();
    endtask

    // Runs one transaction starting in the current cycle (C0). Writes return
    // with the bench positioned in C4, reads in C8 (the done cycle), so a
    // following call starts back-to-back. fs_at pulses frame_start in one
    // read data cycle (4..7), -1 for none.
    task automatic run_txn(input bit is_read, input logic [31:0] addr,
                           input logic [31:0] data, input bit exp_err,
                           input int fs_at, input string name);
        logic [7:0] exp_byte;
        for (int k = 0; k < 4; k++) begin
            frame_start = (k == 0);
            rw          = (k == 0) ? is_read : ~is_read;
            addr_in     = addr[8*k +: 8];
            wdata_in    = is_read ? 8'h00 : data[8*k +: 8];
            if (k > 0) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy/done C%0d: got busy=%b done=%b want 1/0",
                             name, k, busy, done);
                end
            end
            next_cycle();
        end
        frame_start = 1'b0;
        rw          = 1'b0;
        addr_in     = 8'h00;
        wdata_in    = 8'h00;
        if (!is_read) begin
            checks++;
            if (done !== 1'b1 || err !== exp_err || busy !== 1'b0 || rdata_oe !== 1'b0) begin
                errors++;
                $display("FAIL %s write C4: got done=%b err=%b busy=%b oe=%b want 1/%b/0/0",
                         name, done, err, busy, rdata_oe, exp_err);
            end
        end else begin
            for (int k = 4; k < 8; k++) begin
                exp_byte = exp_err ? 8'h00 : data[8*(k-4) +: 8];
                checks++;
                if (rdata_oe !== 1'b1 || rdata_out !== exp_byte || busy !== 1'b1 ||
                    done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s read C%0d: got oe=%b data=%h busy=%b done=%b want 1/%h/1/0",
                             name, k, rdata_oe, rdata_out, busy, done, exp_byte);
                end
                frame_start = (k == fs_at);
                rw          = 1'b1;
                next_cycle();
            end
            frame_start = 1'b0;
            rw          = 1'b0;
            checks++;
            if (done !== 1'b1 || err !== exp_err || busy !== 1'b0 ||
                rdata_oe !== 1'b0 || rdata_out !== 8'h00) begin
                errors++;
                $display("FAIL %s read C8: got done=%b err=%b busy=%b oe=%b data=%h want 1/%b/0/0/00",
                         name, done, err, busy, rdata_oe, rdata_out, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycle();
        idle_cycle();
        checks++;
        if ({rdata_out, rdata_oe, busy, done, err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h oe=%b busy=%b done=%b err=%b want all 0",
                     rdata_out, rdata_oe, busy, done, err);
        end
        // reset wins over a simultaneous frame_start
        frame_start = 1'b1;
        rw          = 1'b1;
        next_cycle();
        rst         = 1'b0;
        frame_start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got busy=%b want 0", busy);
        end
        idle_cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority_after: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_write_read();
        run_txn(1'b0, 32'h0000_0008, 32'hDEADBEEF, 1'b0, -1, "wr8");
        idle_cycle();
        run_txn(1'b1, 32'h0000_0008, 32'hDEADBEEF, 1'b0, -1, "rd8");
        idle_cycle();
        run_txn(1'b0, 32'h0000_0000, 32'h0102_0304, 1'b0, -1, "wr0");
        idle_cycle();
        run_txn(1'b1, 32'h0000_0000, 32'h0102_0304, 1'b0, -1, "rd0");
        idle_cycle();
    endtask

    task automatic test_out_of_range();
        run_txn(1'b1, 32'h0000_0040, 32'h0, 1'b1, -1, "rd_oob40");
        idle_cycle();
        run_txn(1'b1, 32'h0100_0008, 32'h0, 1'b1, -1, "rd_oob_hi");
        idle_cycle();
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 32'h0000_0006, 32'h12345678, 1'b1, -1, "wr_mis6");
        idle_cycle();
        run_txn(1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0, -1, "rd4_after_mis");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'h0000_003C, 32'hA5A5A5A5, 1'b0, -1, "b2b_wr");
        run_txn(1'b1, 32'h0000_003C, 32'hA5A5A5A5, 1'b0, -1, "b2b_rd");
        run_txn(1'b0, 32'h0000_0038, 32'hCAFE_F00D, 1'b0, -1, "b2b_wr2");
        run_txn(1'b1, 32'h0000_0038, 32'hCAFE_F00D, 1'b0, -1, "b2b_rd2");
        idle_cycle();
    endtask

    task automatic test_frame_ignore();
        run_txn(1'b1, 32'h0000_0008, 32'hDEADBEEF, 1'b0, 5, "rd_fs_c5");
        idle_cycle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fs_ignore_after: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < 3; k++) begin
            frame_start = (k == 0);
            rw          = 1'b0;
            addr_in     = 8'h00;
            wdata_in    = 8'h11;
            if (k == 2) rst = 1'b1;
            next_cycle();
        end
        rst = 1'b0;
        frame_start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b err=%b want 0/0/0", busy, done, err);
        end
        for (int k = 0; k < 4; k++) begin
            idle_cycle();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done %0d: got done=%b busy=%b want 0/0", k, done, busy);
            end
        end
        run_txn(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, -1, "rd0_after_abort");
        idle_cycle();
        run_txn(1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0, -1, "rd8_cleared");
        idle_cycle();
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        rw          = 1'b0;
        addr_in     = 8'h00;
        wdata_in    = 8'h00;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_frame_ignore();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
